// File: rtl/symtab_lookup_arb.sv
// Round-robin arbiter sharing the symtab_cam lookup port among lanes and fencing CAM commits behind lookups.
// Grant to rsp_valid in 4+ cycles (timeout at grant+2+TIMEOUT_CYCLES); only one lookup is in flight and req_ready is 0 outside IDLE.
module symtab_lookup_arb #(
  parameter int NUM_REQ        = 4,
  parameter int KEY_WIDTH      = 64,
  parameter int IDX_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*KEY_WIDTH-1:0] req_key,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic                         rsp_hit,
  output logic [IDX_WIDTH-1:0]         rsp_idx,
  output logic                         rsp_timeout,
  output logic [KEY_WIDTH-1:0]         cam_lookup_key,
  output logic                         cam_lookup_valid,
  input  logic [IDX_WIDTH-1:0]         cam_lookup_idx,
  input  logic                         cam_lookup_hit,
  input  logic                         cam_lookup_ready,
  input  logic                         csr_commit_req,
  output logic                         csr_commit_busy,
  output logic                         cam_commit,
  output logic [31:0]                  stat_lookups,
  output logic [31:0]                  stat_hits,
  output logic [15:0]                  stat_timeouts
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT} state_t;

  state_t               state_q;
  logic [LW-1:0]        last_q, lane_q;
  logic [KEY_WIDTH-1:0] key_q;
  logic [CW-1:0]        cnt_q;
  logic                 pend_q, pend_d;
  logic                 lkv_q, commit_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 rsp_hit_q, rsp_to_q;
  logic [IDX_WIDTH-1:0] rsp_idx_q;
  logic [31:0]          lookups_q, hits_q;
  logic [15:0]          timeouts_q, timeouts_d;

  logic                 win_vld;
  logic [LW-1:0]        win_lane, cand;

  // Rotating priority: search starts one lane past the last winner.
  always_comb begin
    win_vld  = 1'b0;
    win_lane = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = LW'((int'(last_q) + i) % NUM_REQ);
      if (!win_vld && req_valid[cand]) begin
        win_vld  = 1'b1;
        win_lane = cand;
      end
    end
  end

  // Gated by rst_n so no grant is visible while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && !pend_q && win_vld) req_ready[win_lane] = 1'b1;
  end

  assign pend_d     = csr_commit_req | (pend_q & (state_q != S_COMMIT));
  assign timeouts_d = (timeouts_q == 16'hFFFF) ? timeouts_q : timeouts_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= LW'(NUM_REQ - 1);
      lane_q      <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      lkv_q       <= 1'b0;
      commit_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_to_q    <= 1'b0;
      lookups_q   <= '0;
      hits_q      <= '0;
      timeouts_q  <= '0;
    end else begin
      lkv_q       <= 1'b0;
      commit_q    <= 1'b0;
      rsp_valid_q <= '0;
      pend_q      <= pend_d;
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            state_q  <= S_COMMIT;
            commit_q <= 1'b1;
          end else if (win_vld) begin
            key_q   <= req_key[win_lane*KEY_WIDTH +: KEY_WIDTH];
            lane_q  <= win_lane;
            last_q  <= win_lane;
            lkv_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cam_lookup_ready) begin
            rsp_valid_q <= NUM_REQ'(1) << lane_q;
            rsp_hit_q   <= cam_lookup_hit;
            rsp_idx_q   <= cam_lookup_idx;
            rsp_to_q    <= 1'b0;
            lookups_q   <= lookups_q + 32'd1;
            if (cam_lookup_hit) hits_q <= hits_q + 32'd1;
            state_q     <= S_IDLE;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_q <= NUM_REQ'(1) << lane_q;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_to_q    <= 1'b1;
            lookups_q   <= lookups_q + 32'd1;
            timeouts_q  <= timeouts_d;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_COMMIT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_idx          = rsp_idx_q;
  assign rsp_timeout      = rsp_to_q;
  assign cam_lookup_key   = key_q;
  assign cam_lookup_valid = lkv_q;
  assign cam_commit       = commit_q;
  assign csr_commit_busy  = pend_q | (state_q == S_COMMIT);
  assign stat_lookups     = lookups_q;
  assign stat_hits        = hits_q;
  assign stat_timeouts    = timeouts_q;

endmodule

// File: tb/tb_symtab_lookup_arb.sv
// Directed bench for symtab_lookup_arb with a behavioural CAM of programmable probe latency.
module tb_symtab_lookup_arb;
  localparam int NR = 4;
  localparam int KW = 64;
  localparam int IW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*KW-1:0] req_key = '0;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic            rsp_hit, rsp_timeout;
  logic [IW-1:0]   rsp_idx;
  logic [KW-1:0]   cam_lookup_key;
  logic            cam_lookup_valid;
  logic [IW-1:0]   cam_lookup_idx = '0;
  logic            cam_lookup_hit = 1'b0;
  logic            cam_lookup_ready = 1'b0;
  logic            csr_commit_req = 1'b0;
  logic            csr_commit_busy, cam_commit;
  logic [31:0]     stat_lookups, stat_hits;
  logic [15:0]     stat_timeouts;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cam_lat = 2;
  bit cam_never = 1'b0;
  bit force_ready = 1'b0;

  symtab_lookup_arb #(.NUM_REQ(NR), .KEY_WIDTH(KW), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .rsp_timeout(rsp_timeout),
    .cam_lookup_key(cam_lookup_key), .cam_lookup_valid(cam_lookup_valid),
    .cam_lookup_idx(cam_lookup_idx), .cam_lookup_hit(cam_lookup_hit),
    .cam_lookup_ready(cam_lookup_ready), .csr_commit_req(csr_commit_req),
    .csr_commit_busy(csr_commit_busy), .cam_commit(cam_commit),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_timeouts(stat_timeouts));

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(int idx);
    return {48'hA5A5_5A5A_0000, 6'b0, 10'(idx)};
  endfunction

  // CAM model: ready strobes cam_lat cycles after the launch cycle; loaded keys hit with idx = low bits.
  initial begin
    int cd;
    logic [63:0] mkey;
    cd = 0;
    mkey = '0;
    forever begin
      @(posedge clk);
      #3;
      cam_lookup_ready = 1'b0;
      cam_lookup_hit   = 1'b0;
      cam_lookup_idx   = '0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            cam_lookup_ready = 1'b1;
            cam_lookup_hit   = (mkey[63:16] == 48'hA5A5_5A5A_0000);
            cam_lookup_idx   = cam_lookup_hit ? mkey[9:0] : 10'd0;
          end
        end
        if (force_ready) begin
          cam_lookup_ready = 1'b1;
          cam_lookup_hit   = 1'b1;
          cam_lookup_idx   = 10'd5;
        end
        if (cam_lookup_valid && !cam_never) begin
          cd   = cam_lat;
          mkey = cam_lookup_key;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_key(int lane, logic [63:0] k);
    req_key[lane*KW +: KW] = k;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if ({rsp_hit, rsp_timeout, cam_lookup_valid, cam_commit, csr_commit_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {rsp_hit, rsp_timeout, cam_lookup_valid, cam_commit, csr_commit_busy}); end
    checks++; if ({rsp_idx, cam_lookup_key} !== '0) begin errors++; $display("FAIL reset_idx_key: got %h want 0", {rsp_idx, cam_lookup_key}); end
    checks++; if ({stat_lookups, stat_hits, stat_timeouts} !== '0) begin errors++; $display("FAIL reset_stats: got %h want 0", {stat_lookups, stat_hits, stat_timeouts}); end
    req_valid = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_hit();
    step();
    set_key(2, mk(37));
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hit_grant: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    checks++; if (cam_lookup_valid !== 1'b1) begin errors++; $display("FAIL hit_launch: got %b want 1", cam_lookup_valid); end
    checks++; if (cam_lookup_key !== mk(37)) begin errors++; $display("FAIL hit_key: got %h want %h", cam_lookup_key, mk(37)); end
    step();
    checks++; if (cam_lookup_valid !== 1'b0) begin errors++; $display("FAIL hit_launch_pulse: got %b want 0", cam_lookup_valid); end
    step();
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL hit_early_rsp: got %b want 0000", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL hit_rsp_valid: got %b want 0100", rsp_valid); end
    checks++; if ({rsp_hit, rsp_timeout} !== 2'b10) begin errors++; $display("FAIL hit_flags: got %b want 10", {rsp_hit, rsp_timeout}); end
    checks++; if (rsp_idx !== 10'd37) begin errors++; $display("FAIL hit_idx: got %0d want 37", rsp_idx); end
    checks++; if (stat_hits !== 32'd1 || stat_lookups !== 32'd1) begin errors++; $display("FAIL hit_stats: got %0d/%0d want 1/1", stat_hits, stat_lookups); end
    step();
    checks++; if (rsp_valid !== 4'b0 || rsp_idx !== 10'd37) begin errors++; $display("FAIL hit_hold: got %b/%0d want 0000/37", rsp_valid, rsp_idx); end
  endtask

  task automatic test_round_robin();
    int n;
    int prev;
    logic [3:0] oh;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) set_key(i, mk(10 + i));
    req_valid = 4'hF;
    step();
    step();
    rst_n = 1'b1;
    #1;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready === 4'b0 && n < 10) begin
        step();
        #1;
        n++;
      end
      oh = 4'b0001 << (g % 4);
      checks++; if (req_ready !== oh) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, oh); end
      if (g > 0) begin
        checks++; if (cyc - prev !== 4) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 4", g, cyc - prev); end
      end
      prev = cyc;
      repeat (4) step();
      checks++; if (rsp_valid !== oh || rsp_idx !== IW'(10 + g % 4)) begin
        errors++; $display("FAIL rr_rsp%0d: got %b/%0d want %b/%0d", g, rsp_valid, rsp_idx, oh, 10 + g % 4); end
      if (g == 4) req_valid = '0;
      #1;
    end
  endtask

  task automatic test_commit_inflight();
    cam_lat = 4;
    step();
    set_key(0, mk(100));
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ci_grant: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    csr_commit_req = 1'b1;
    step();
    csr_commit_req = 1'b0;
    set_key(1, mk(200));
    req_valid = 4'b0010;
    for (int k = 2; k <= 6; k++) begin
      if (k > 2) step();
      #1;
      checks++; if (req_ready !== 4'b0 || cam_commit !== 1'b0 || csr_commit_busy !== 1'b1) begin
        errors++; $display("FAIL ci_fence_t%0d: got rdy=%b commit=%b busy=%b want 0000/0/1", k, req_ready, cam_commit, csr_commit_busy); end
    end
    checks++; if (rsp_valid !== 4'b0001 || rsp_idx !== 10'd100 || rsp_hit !== 1'b1) begin
      errors++; $display("FAIL ci_rsp: got %b/%0d/%b want 0001/100/1", rsp_valid, rsp_idx, rsp_hit); end
    step();
    checks++; if (cam_commit !== 1'b1 || csr_commit_busy !== 1'b1 || req_ready !== 4'b0) begin
      errors++; $display("FAIL ci_commit: got commit=%b busy=%b rdy=%b want 1/1/0000", cam_commit, csr_commit_busy, req_ready); end
    step();
    cam_lat = 2;
    checks++; if (cam_commit !== 1'b0 || csr_commit_busy !== 1'b0 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL ci_after: got commit=%b busy=%b rdy=%b want 0/0/0010", cam_commit, csr_commit_busy, req_ready); end
    step();
    req_valid = '0;
    repeat (3) step();
    checks++; if (rsp_valid !== 4'b0010 || rsp_idx !== 10'd200) begin errors++; $display("FAIL ci_lane1_rsp: got %b/%0d want 0010/200", rsp_valid, rsp_idx); end
  endtask

  task automatic test_timeout();
    cam_never = 1'b1;
    step();
    set_key(3, mk(55));
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_grant: got %b want 1000", req_ready); end
    step();
    req_valid = '0;
    for (int k = 1; k <= 17; k++) begin
      checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL to_early_t%0d: got %b want 0000", k, rsp_valid); end
      step();
    end
    checks++; if (rsp_valid !== 4'b1000) begin errors++; $display("FAIL to_rsp_valid: got %b want 1000", rsp_valid); end
    checks++; if ({rsp_hit, rsp_timeout} !== 2'b01 || rsp_idx !== 10'd0) begin
      errors++; $display("FAIL to_rsp: got hit=%b to=%b idx=%0d want 0/1/0", rsp_hit, rsp_timeout, rsp_idx); end
    checks++; if (stat_timeouts !== 16'd1 || stat_lookups !== 32'd8 || stat_hits !== 32'd7) begin
      errors++; $display("FAIL to_stats: got to=%0d lk=%0d hit=%0d want 1/8/7", stat_timeouts, stat_lookups, stat_hits); end
    force_ready = 1'b1;
    step();
    force_ready = 1'b0;
    cam_never = 1'b0;
    checks++; if (rsp_valid !== 4'b0 || stat_lookups !== 32'd8 || rsp_timeout !== 1'b1) begin
      errors++; $display("FAIL to_late_ready: got %b/%0d/%b want 0000/8/1", rsp_valid, stat_lookups, rsp_timeout); end
  endtask

  task automatic test_simultaneous();
    step();
    csr_commit_req = 1'b1;
    step();
    csr_commit_req = 1'b0;
    set_key(0, mk(1));
    set_key(1, mk(2));
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0 || csr_commit_busy !== 1'b1) begin
      errors++; $display("FAIL sim_no_grant: got rdy=%b busy=%b want 0000/1", req_ready, csr_commit_busy); end
    step();
    checks++; if (cam_commit !== 1'b1 || req_ready !== 4'b0) begin errors++; $display("FAIL sim_commit1: got %b/%b want 1/0000", cam_commit, req_ready); end
    csr_commit_req = 1'b1;
    step();
    csr_commit_req = 1'b0;
    #1;
    checks++; if (cam_commit !== 1'b0 || csr_commit_busy !== 1'b1 || req_ready !== 4'b0) begin
      errors++; $display("FAIL sim_gap: got commit=%b busy=%b rdy=%b want 0/1/0000", cam_commit, csr_commit_busy, req_ready); end
    step();
    checks++; if (cam_commit !== 1'b1) begin errors++; $display("FAIL sim_commit2: got %b want 1", cam_commit); end
    cam_never = 1'b1;
    step();
    checks++; if (cam_commit !== 1'b0 || req_ready !== 4'b0001) begin errors++; $display("FAIL sim_grant: got %b/%b want 0/0001", cam_commit, req_ready); end
  endtask

  task automatic test_reset_mid_wait();
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || cam_lookup_valid !== 1'b0 || cam_lookup_key !== '0) begin
      errors++; $display("FAIL rst_outputs: got rdy=%b rsp=%b lv=%b key=%h want all 0", req_ready, rsp_valid, cam_lookup_valid, cam_lookup_key); end
    checks++; if ({stat_lookups, stat_hits, stat_timeouts, rsp_idx, rsp_hit, rsp_timeout} !== '0) begin
      errors++; $display("FAIL rst_stats: got %0d/%0d/%0d idx=%0d want 0", stat_lookups, stat_hits, stat_timeouts, rsp_idx); end
    step();
    step();
    rst_n = 1'b1;
    cam_never = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_stale_rsp_t%0d: got %b want 0000", k, rsp_valid); end
      step();
    end
    checks++; if (rsp_valid !== 4'b0001 || rsp_idx !== 10'd1 || stat_lookups !== 32'd1) begin
      errors++; $display("FAIL rst_new_rsp: got %b/%0d/%0d want 0001/1/1", rsp_valid, rsp_idx, stat_lookups); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_hit();
    test_round_robin();
    test_commit_inflight();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
